// File: rtl/mc_datapath_p.sv
// rtl/mc_datapath_p.sv - multi-cycle CPU datapath: X mux, Y reg, 8-function ALU, flags, reg bank, IR decode, memory handshake FSM
// Optional feature macro: DP_STACK_EN (stack pointer on X source 0 with ld_sp/sp_inc/sp_dec).
module mc_datapath_p #(
    parameter int              WIDTH    = 16,
    parameter int              NREG     = 8,
    parameter logic [WIDTH-1:0] PC_RESET = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2:0]               xsel,
    input  logic                     ld_ir,
    input  logic                     ld_mdr,
    input  logic                     ld_mar,
    input  logic                     ld_pc,
    input  logic                     ld_r,
    input  logic                     ld_y,
    input  logic [2:0]               fun_sel,
    input  logic                     fl_we,
    input  logic                     reg_we,
`ifdef DP_STACK_EN
    input  logic                     ld_sp,
    input  logic                     sp_inc,
    input  logic                     sp_dec,
`endif
    input  logic [$clog2(NREG)-1:0]  reg_rd_addr,
    input  logic [$clog2(NREG)-1:0]  reg_wr_addr,
    input  logic                     mem_start,
    input  logic                     mem_we,
    output logic                     mem_req,
    output logic                     mem_wr,
    output logic [WIDTH-1:0]         mem_addr,
    output logic [WIDTH-1:0]         mem_wdata,
    input  logic [WIDTH-1:0]         mem_rdata,
    input  logic                     mem_ack,
    output logic                     busy,
    output logic                     mem_done,
    output logic [3:0]               flags,
    output logic [4:0]               op_code,
    output logic [1:0]               addr_mode,
    output logic [2:0]               dst,
    output logic [2:0]               src1,
    output logic [2:0]               src2
);

    typedef enum logic {IDLE, REQ} mem_state_t;

    mem_state_t       state, state_nxt;
    logic             start_acc, ack_acc;
    logic [WIDTH-1:0] ir, mdr, mar, pc, r, y;
    logic [WIDTH-1:0] x, z;
    logic [WIDTH:0]   sum_add, sum_sub;
    logic             c_out, v_out;
    logic [WIDTH-1:0] bank [NREG];
`ifdef DP_STACK_EN
    logic [WIDTH-1:0] sp;
`endif

    // Memory transaction FSM
    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        ack_acc   = 1'b0;
        case (state)
            IDLE: begin
                if (mem_start) begin
                    state_nxt = REQ;
                    start_acc = 1'b1;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_nxt = IDLE;
                    ack_acc   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            mem_wr   <= 1'b0;
            mem_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            mem_done <= ack_acc;
            if (start_acc)
                mem_wr <= mem_we;
            else if (ack_acc)
                mem_wr <= 1'b0;
        end
    end

    assign busy      = (state == REQ);
    assign mem_req   = busy;
    assign mem_addr  = mar;
    assign mem_wdata = mdr;

    // X source bus
    always_comb begin
        x = '0;
        case (xsel)
`ifdef DP_STACK_EN
            3'd0: x = sp;
`else
            3'd0: x = '0;
`endif
            3'd1: x = mdr;
            3'd2: x = mar;
            3'd3: x = pc;
            3'd4: x = r;
            3'd5: x = bank[reg_rd_addr];
            3'd6: x = WIDTH'(2);
            3'd7: x = WIDTH'(4);
            default: x = '0;
        endcase
    end

    // SUB is Y + ~X + 1 so its carry out is already "not borrow"
    assign sum_add = {1'b0, y} + {1'b0, x};
    assign sum_sub = {1'b0, y} + {1'b0, ~x} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        z     = '0;
        c_out = 1'b0;
        v_out = 1'b0;
        case (fun_sel)
            3'd0: begin
                z     = sum_add[WIDTH-1:0];
                c_out = sum_add[WIDTH];
                v_out = (y[WIDTH-1] == x[WIDTH-1]) && (sum_add[WIDTH-1] != y[WIDTH-1]);
            end
            3'd1: begin
                z     = sum_sub[WIDTH-1:0];
                c_out = sum_sub[WIDTH];
                v_out = (y[WIDTH-1] != x[WIDTH-1]) && (sum_sub[WIDTH-1] != y[WIDTH-1]);
            end
            3'd2: z = y & x;
            3'd3: z = y | x;
            3'd4: z = y ^ x;
            3'd5: z = ~x;
            3'd6: z = x;
            3'd7: begin
                z     = {x[WIDTH-2:0], 1'b0};
                c_out = x[WIDTH-1];
            end
            default: z = '0;
        endcase
    end

    // MAR/MDR are frozen while a transaction is pending so the memory sees stable values
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir    <= '0;
            mdr   <= '0;
            mar   <= '0;
            pc    <= PC_RESET;
            r     <= '0;
            y     <= '0;
            flags <= 4'b0000;
        end else begin
            if (ld_ir) ir <= z;
            if (ld_pc) pc <= z;
            if (ld_r)  r  <= z;
            if (ld_y)  y  <= x;
            if (ld_mar && !busy) mar <= z;
            if (ack_acc && !mem_wr)
                mdr <= mem_rdata;
            else if (ld_mdr && !busy)
                mdr <= z;
            if (fl_we) flags <= {(z == '0), z[WIDTH-1], c_out, v_out};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) bank[i] <= '0;
        end else if (reg_we) begin
            bank[reg_wr_addr] <= z;
        end
    end

`ifdef DP_STACK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            sp <= '0;
        else if (ld_sp)
            sp <= z;
        else if (sp_inc && !sp_dec)
            sp <= sp + WIDTH'(2);
        else if (sp_dec && !sp_inc)
            sp <= sp - WIDTH'(2);
    end
`endif

    assign op_code   = ir[15:11];
    assign addr_mode = ir[10:9];
    assign dst       = ir[8:6];
    assign src1      = ir[5:3];
    assign src2      = ir[2:0];

endmodule

// File: tb/tb_mc_datapath_p.sv
// tb/tb_mc_datapath_p.sv - directed self-checking bench for mc_datapath_p
module tb_mc_datapath_p;

    localparam int W = 16;

    localparam logic [7:0] L_IR  = 8'h01;
    localparam logic [7:0] L_MDR = 8'h02;
    localparam logic [7:0] L_MAR = 8'h04;
    localparam logic [7:0] L_PC  = 8'h08;
    localparam logic [7:0] L_R   = 8'h10;
    localparam logic [7:0] L_Y   = 8'h20;
    localparam logic [7:0] L_FL  = 8'h40;
    localparam logic [7:0] L_REG = 8'h80;

    localparam logic [2:0] F_ADD = 3'd0, F_SUB = 3'd1, F_AND = 3'd2, F_OR = 3'd3;
    localparam logic [2:0] F_XOR = 3'd4, F_NOT = 3'd5, F_PASS = 3'd6, F_SHL = 3'd7;
    localparam logic [2:0] X_ZERO = 3'd0, X_MDR = 3'd1, X_PC = 3'd3, X_R = 3'd4;
    localparam logic [2:0] X_BANK = 3'd5, X_C2 = 3'd6, X_C4 = 3'd7;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   xsel = '0;
    logic         ld_ir = 0, ld_mdr = 0, ld_mar = 0, ld_pc = 0, ld_r = 0, ld_y = 0;
    logic [2:0]   fun_sel = '0;
    logic         fl_we = 0, reg_we = 0;
    logic [2:0]   reg_rd_addr = '0, reg_wr_addr = '0;
    logic         mem_start = 0, mem_we = 0;
    logic         mem_req, mem_wr;
    logic [W-1:0] mem_addr, mem_wdata;
    logic [W-1:0] mem_rdata = '0;
    logic         mem_ack = 0;
    logic         busy, mem_done;
    logic [3:0]   flags;
    logic [4:0]   op_code;
    logic [1:0]   addr_mode;
    logic [2:0]   dst, src1, src2;
`ifdef DP_STACK_EN
    logic         ld_sp = 0, sp_inc = 0, sp_dec = 0;
`endif

    int errors = 0;
    int checks = 0;
    int busy_cycles;

    mc_datapath_p #(.WIDTH(W), .NREG(8), .PC_RESET(16'h0100)) dut (
        .clk(clk), .rst(rst), .xsel(xsel),
        .ld_ir(ld_ir), .ld_mdr(ld_mdr), .ld_mar(ld_mar), .ld_pc(ld_pc), .ld_r(ld_r), .ld_y(ld_y),
        .fun_sel(fun_sel), .fl_we(fl_we), .reg_we(reg_we),
`ifdef DP_STACK_EN
        .ld_sp(ld_sp), .sp_inc(sp_inc), .sp_dec(sp_dec),
`endif
        .reg_rd_addr(reg_rd_addr), .reg_wr_addr(reg_wr_addr),
        .mem_start(mem_start), .mem_we(mem_we), .mem_req(mem_req), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .busy(busy), .mem_done(mem_done), .flags(flags),
        .op_code(op_code), .addr_mode(addr_mode), .dst(dst), .src1(src1), .src2(src2)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [2:0] xs, input logic [2:0] fn, input logic [7:0] m);
        xsel = xs; fun_sel = fn;
        ld_ir = m[0]; ld_mdr = m[1]; ld_mar = m[2]; ld_pc = m[3];
        ld_r = m[4]; ld_y = m[5]; fl_we = m[6]; reg_we = m[7];
        cyc();
        ld_ir = 0; ld_mdr = 0; ld_mar = 0; ld_pc = 0;
        ld_r = 0; ld_y = 0; fl_we = 0; reg_we = 0;
    endtask

    // Minimum-latency read: ack in the first request cycle
    task automatic mem_load(input logic [W-1:0] d);
        mem_start = 1; mem_we = 0;
        cyc();
        mem_start = 0; mem_rdata = d; mem_ack = 1;
        cyc();
        mem_ack = 0; mem_rdata = '0;
    endtask

    initial begin
        #1 rst = 1'b0;
        #2;
        chk("rst_flags", flags, 4'b0000);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_done", mem_done, 1'b0);
        chk("rst_mar", mem_addr, 16'h0000);
        #9 rst = 1'b1;
        cyc();

        go(X_PC, F_PASS, L_MDR);
        chk("rst_pc", mem_wdata, 16'h0100);
        go(X_ZERO, F_PASS, L_MDR);
        chk("xsel0_zero", mem_wdata, 16'h0000);

        // ALU
        mem_load(16'h7FFF);
        chk("load_7fff", mem_wdata, 16'h7FFF);
        go(X_MDR, F_PASS, L_Y);
        go(X_C2, F_ADD, L_FL | L_MDR);
        chk("add_ovf_z", mem_wdata, 16'h8001);
        chk("add_ovf_fl", flags, 4'b0101);
        go(X_C2, F_PASS, L_Y);
        go(X_C2, F_SUB, L_FL | L_MDR);
        chk("sub_zero_z", mem_wdata, 16'h0000);
        chk("sub_zero_fl", flags, 4'b1010);
        go(X_C4, F_SUB, L_FL | L_MDR);
        chk("sub_borrow_z", mem_wdata, 16'hFFFE);
        chk("sub_borrow_fl", flags, 4'b0100);
        go(X_C4, F_AND, L_FL | L_MDR);
        chk("and_z", mem_wdata, 16'h0000);
        chk("and_fl", flags, 4'b1000);
        go(X_C4, F_OR, L_FL | L_MDR);
        chk("or_z", mem_wdata, 16'h0006);
        chk("or_fl", flags, 4'b0000);
        go(X_MDR, F_XOR, L_FL | L_MDR);
        chk("xor_z", mem_wdata, 16'h0004);
        go(X_C4, F_NOT, L_FL | L_MDR);
        chk("not_z", mem_wdata, 16'hFFFB);
        chk("not_fl", flags, 4'b0100);
        go(X_MDR, F_SHL, L_FL | L_MDR);
        chk("shl_z", mem_wdata, 16'hFFF6);
        chk("shl_fl", flags, 4'b0110);
        go(X_MDR, F_PASS, L_Y);
        go(X_MDR, F_ADD, L_FL | L_MDR);
        chk("add_carry_z", mem_wdata, 16'hFFEC);
        chk("add_carry_fl", flags, 4'b0110);
        go(X_C2, F_PASS, L_MDR);
        chk("flags_hold", flags, 4'b0110);

        // R, PC, register bank
        go(X_C4, F_PASS, L_R | L_PC);
        go(X_R, F_PASS, L_MDR);
        chk("r_load", mem_wdata, 16'h0004);
        go(X_PC, F_PASS, L_MDR);
        chk("pc_load", mem_wdata, 16'h0004);
        reg_wr_addr = 3'd7;
        go(X_C2, F_PASS, L_REG);
        reg_rd_addr = 3'd7;
        go(X_BANK, F_SHL, L_REG | L_MDR);
        chk("bank_rdw_old", mem_wdata, 16'h0004);
        go(X_BANK, F_PASS, L_MDR);
        chk("bank_after_wr", mem_wdata, 16'h0004);
        reg_rd_addr = 3'd0;
        go(X_BANK, F_PASS, L_MDR);
        chk("bank_other", mem_wdata, 16'h0000);

        // IR decode
        mem_load(16'h9B5E);
        go(X_MDR, F_PASS, L_IR);
        chk("ir_op", op_code, 5'd19);
        chk("ir_mode", addr_mode, 2'd1);
        chk("ir_dst", dst, 3'd5);
        chk("ir_src1", src1, 3'd3);
        chk("ir_src2", src2, 3'd6);

        // Memory read with 3 wait cycles
        mem_load(16'h0040);
        go(X_MDR, F_PASS, L_MAR);
        chk("mar_load", mem_addr, 16'h0040);
        mem_start = 1; mem_we = 0;
        cyc();
        mem_start = 0;
        chk("rd_req", mem_req, 1'b1);
        chk("rd_wr", mem_wr, 1'b0);
        busy_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            if (busy) busy_cycles++;
            if (i == 3) begin
                mem_ack = 1; mem_rdata = 16'hBEEF;
            end
            cyc();
        end
        mem_ack = 0; mem_rdata = '0;
        chk("rd_mdr", mem_wdata, 16'hBEEF);
        chk("rd_done", mem_done, 1'b1);
        chk("rd_busy_low", busy, 1'b0);
        chk("rd_busy_cycles", busy_cycles, 4);
        cyc();
        chk("rd_done_pulse", mem_done, 1'b0);

        // Memory write with ignored loads and start while busy
        mem_start = 1; mem_we = 1;
        cyc();
        mem_start = 0; mem_we = 0;
        chk("wr_req", mem_req, 1'b1);
        chk("wr_wr", mem_wr, 1'b1);
        mem_start = 1;
        go(X_C2, F_PASS, L_MDR | L_MAR);
        mem_start = 0;
        chk("wr_wdata_held", mem_wdata, 16'hBEEF);
        chk("wr_addr_held", mem_addr, 16'h0040);
        mem_ack = 1; mem_rdata = 16'h1234;
        cyc();
        mem_ack = 0; mem_rdata = '0;
        chk("wr_done", mem_done, 1'b1);
        chk("wr_mdr_kept", mem_wdata, 16'hBEEF);
        chk("wr_single", busy, 1'b0);

        // Back-to-back start in the done cycle, then reset mid-transaction
        mem_start = 1; mem_we = 1;
        cyc();
        mem_start = 0; mem_we = 0;
        chk("b2b_req", mem_req, 1'b1);
        #3 rst = 1'b0;
        #1;
        chk("arst_req", mem_req, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_wr", mem_wr, 1'b0);
        chk("arst_mdr", mem_wdata, 16'h0000);
        chk("arst_flags", flags, 4'b0000);
        mem_ack = 1; mem_rdata = 16'hDEAD;
        cyc();
        rst = 1'b1;
        cyc();
        cyc();
        mem_ack = 0; mem_rdata = '0;
        chk("stray_ack_busy", busy, 1'b0);
        chk("stray_ack_done", mem_done, 1'b0);
        chk("stray_ack_mdr", mem_wdata, 16'h0000);
        go(X_PC, F_PASS, L_MDR);
        chk("arst_pc", mem_wdata, 16'h0100);

`ifdef DP_STACK_EN
        sp_dec = 1;
        cyc();
        sp_dec = 0;
        go(X_ZERO, F_PASS, L_MDR);
        chk("sp_dec_wrap", mem_wdata, 16'hFFFE);
        sp_inc = 1; sp_dec = 1;
        cyc();
        sp_inc = 0; sp_dec = 0;
        go(X_ZERO, F_PASS, L_MDR);
        chk("sp_inc_dec", mem_wdata, 16'hFFFE);
        mem_load(16'h1000);
        ld_sp = 1; sp_inc = 1;
        go(X_MDR, F_PASS, 8'h00);
        ld_sp = 0; sp_inc = 0;
        go(X_ZERO, F_PASS, L_MDR);
        chk("sp_ld_wins", mem_wdata, 16'h1000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
